// File: rtl/mem_r_result.sv
// Capture buffer for one frame of FFT results: streamed writes at incrementing
// addresses, Inf/NaN tally, sticky overrun flag and a registered read port.
module mem_r_result #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int FRAME_LEN  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   nan_cnt,
  output logic                  overrun,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0] LEN  = (ADDR_WIDTH + 1)'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  xfer;
  logic                  is_nan;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;

  // A start in the same cycle as a transfer discards that transfer.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_CAPTURE);
    done      = (state == S_DONE);
    xfer      = in_valid & in_ready & ~start;
    if (start)
      state_nxt = S_CAPTURE;
    else if (xfer && (count == LAST))
      state_nxt = S_DONE;
  end

  assign is_nan      = (in_data[30:23] == 8'hFF);
  assign wr_idx      = count[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign rd_in_range = ({1'b0, rd_addr} < LEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      nan_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        count   <= '0;
        nan_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        if (xfer) begin
          count <= count + 1'b1;
          if (is_nan)
            nan_cnt <= nan_cnt + 1'b1;
        end
        if (in_valid && !in_ready)
          overrun <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_idx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= rd_in_range ? mem[rd_idx] : '0;
  end

endmodule

// File: tb/tb_mem_r_result.sv
// Directed plus randomized bench for mem_r_result against a frame-level model.
module tb_mem_r_result;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int FL = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          done;
  logic [AW:0]   count;
  logic [AW:0]   nan_cnt;
  logic          overrun;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  mem_r_result #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .done(done), .count(count), .nan_cnt(nan_cnt),
    .overrun(overrun), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level reference: capturing / finished flags plus a word store.
  bit          m_cap, m_done, m_ov;
  int          m_cnt, m_nan;
  logic [31:0] mmem  [FL];
  bit          known [FL];

  logic [31:0] basic_words [FL] = '{32'h00000000, 32'h00000000, 32'hBF3504F3,
                                    32'hBF800000, 32'hBF3504F3, 32'hA50D3131,
                                    32'h3F3504F3, 32'h3F800000, 32'h3F3504F3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_ov = 0; m_cnt = 0; m_nan = 0;
    for (int i = 0; i < FL; i++) known[i] = 0;
  endtask

  task automatic cycle(input bit s, input bit v, input logic [31:0] d, input logic [AW-1:0] ra);
    logic [31:0] exp_rd;
    bit          rd_chk;
    start = s; in_valid = v; in_data = d; rd_addr = ra;
    @(posedge clk);
    rd_chk = 1; exp_rd = '0;
    if (int'(ra) < FL) begin
      if (known[ra]) exp_rd = mmem[ra];
      else rd_chk = 0;
    end
    if (s) begin
      m_cap = 1; m_done = 0; m_cnt = 0; m_nan = 0; m_ov = 0;
    end else if (m_cap && v) begin
      mmem[m_cnt] = d; known[m_cnt] = 1; m_cnt++;
      if (d[30:23] == 8'hFF) m_nan++;
      if (m_cnt == FL) begin m_cap = 0; m_done = 1; end
    end else if (!m_cap && v) begin
      m_ov = 1;
    end
    #1;
    chk("in_ready", in_ready, m_cap);
    chk("done", done, m_done);
    chk("count", count, m_cnt);
    chk("nan_cnt", nan_cnt, m_nan);
    chk("overrun", overrun, m_ov);
    if (rd_chk) chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0);
  endtask

  initial begin
    logic [31:0] w;
    int guard;
    start = 0; in_valid = 0; in_data = '0; rd_addr = '0;
    rst = 1;
    model_reset();
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_nan", nan_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clk); #1 rst = 0;

    // basic back-to-back frame and read-back
    cycle(1, 0, '0, '0);
    for (int i = 0; i < FL; i++) cycle(0, 1, basic_words[i], '0);
    chk("basic_done", done, 1);
    chk("basic_count", count, 9);
    chk("basic_nan", nan_cnt, 0);
    for (int i = 0; i <= FL; i++) cycle(0, 0, '0, AW'(i));
    cycle(0, 0, '0, AW'(9));
    chk("basic_rd_oob", rd_data, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, AW'($urandom_range(9, 4095)));

    // bubbled input
    cycle(1, 0, '0, '0);
    guard = 0;
    while (!m_done && guard < 40) begin
      cycle(0, guard[0] == 0, $urandom, AW'($urandom_range(0, 9)));
      guard++;
    end
    chk("bubble_done", done, 1);
    chk("bubble_cycles", guard, 17);
    for (int i = 0; i < FL; i++) cycle(0, 0, '0, AW'(i));

    // Inf/NaN counting with max-finite not counted
    cycle(1, 0, '0, '0);
    for (int i = 0; i < FL; i++) begin
      case (i)
        1: w = 32'h7FC00000;
        4: w = 32'hFF800000;
        6: w = 32'h7F7FFFFF;
        default: w = {$urandom_range(0, 1), 8'h3F, 23'($urandom)};
      endcase
      cycle(0, 1, w, AW'(i));
    end
    chk("nan_two", nan_cnt, 2);

    // overrun in IDLE and after done
    rst = 1; #1; rst = 0;
    model_reset();
    cycle(0, 1, $urandom, '0);
    chk("ov_idle", overrun, 1);
    cycle(1, 0, '0, '0);
    chk("ov_cleared", overrun, 0);
    for (int i = 0; i < FL; i++) cycle(0, 1, $urandom, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, '0);
    chk("ov_done", overrun, 1);
    chk("ov_count", count, 9);
    cycle(0, 0, '0, '0);
    cycle(1, 0, '0, '0);
    chk("ov_restart", overrun, 0);
    chk("ov_restart_done", done, 0);

    // abort at count=4 and restart (transfer during start discarded)
    for (int i = 0; i < 4; i++) cycle(0, 1, $urandom, '0);
    chk("abort_pre", count, 4);
    cycle(1, 1, 32'hDEADBEEF, '0);
    chk("abort_count", count, 0);
    cycle(0, 1, 32'h40000000, '0);
    cycle(0, 0, '0, '0);
    chk("abort_mem0", rd_data, 32'h40000000);
    for (int i = 1; i < FL; i++) cycle(0, 1, 32'h40000000, AW'(i));
    chk("abort_done", done, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 5) == 0) ? {$urandom_range(0, 1), 8'hFF, 23'($urandom)} : $urandom,
            AW'($urandom_range(0, 11)));

    // async reset mid-capture at count=5
    cycle(1, 0, '0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, '0);
    chk("ar_pre", count, 5);
    #2 rst = 1;
    #1;
    chk("ar_in_ready", in_ready, 0);
    chk("ar_done", done, 0);
    chk("ar_count", count, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_r_result.md
Name: mem_r_result

Overview:
- Capture buffer at the output end of the FFT datapath; the write-side counterpart of the input-sample ROM.
- Accepts a frame of FRAME_LEN IEEE-754 single-precision results over a valid/ready stream and stores them at auto-incrementing addresses.
- Raises done when the frame is complete.
- Offers a registered random-access read port (1-cycle latency) for the bench or downstream logic; counts Inf/NaN results and flags dropped samples.

Parameters:
- DATA_WIDTH, 32, sample width (IEEE-754 single: sign[31], exponent[30:23], mantissa[22:0]).
- ADDR_WIDTH, 12, address width of storage and read port.
- FRAME_LEN, 9, samples per frame. Legal range 1..2^ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse: arm capture of a new frame.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  result sample.
- in_ready  output  1  buffer accepts a sample this cycle.
- done  output  1  frame complete; held until the next start.
- count  output  ADDR_WIDTH+1  samples written in the current frame.
- nan_cnt  output  ADDR_WIDTH+1  accepted samples with exponent == 8'hFF in the current frame.
- overrun  output  1  sticky: in_valid seen while in_ready low.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (async, rst=1):
  - state IDLE.
  - in_ready=0, done=0, count=0, nan_cnt=0, overrun=0, rd_data=0.
  - Storage contents are undefined and are not cleared.
- States and outputs:
  - IDLE: waits for start.
  - CAPTURE: in_ready=1. in_ready is decoded from the state register only; no combinational path from in_valid.
  - DONE: done=1, in_ready=0.
- Transitions:
  - Any state + start -> CAPTURE on the next edge. This clears count, nan_cnt, overrun and done. The same-cycle in_valid is ignored because in_ready is low in IDLE/DONE.
  - start during CAPTURE aborts the current frame. count and nan_cnt restart at 0; the transfer in that cycle (if any) is discarded. Stored words from the aborted frame persist until overwritten.
  - CAPTURE + transfer (in_valid & in_ready):
    - mem[count] <= in_data; count <= count+1.
    - nan_cnt increments if in_data[30:23] == 8'hFF.
  - Transfer with count == FRAME_LEN-1 -> DONE on the same edge. in_ready is low the following cycle, so exactly FRAME_LEN words are stored.
  - FRAME_LEN == 1: the first transfer goes directly to DONE.
- Overrun: in_valid=1 while in_ready=0 (IDLE or DONE) drops the sample and sets overrun. overrun stays set until start or reset.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, regardless of state (1-cycle latency).
  - rd_addr >= FRAME_LEN returns 0.
  - A read and write to the same address in the same cycle returns the old word (read-before-write).
- count and nan_cnt never exceed FRAME_LEN; no wrap-around.
- Asserting reset mid-frame returns to IDLE immediately; stored words are not guaranteed.

Test Plan:
- Basic frame:
  - Stimulus: reset; start; stream 9 words back-to-back: 0x00000000, 0x00000000, 0xBF3504F3, 0xBF800000, 0xBF3504F3, 0xA50D3131, 0x3F3504F3, 0x3F800000, 0x3F3504F3.
  - Required response: done rises the edge after the 9th transfer; count=9; nan_cnt=0.
  - Read-back: rd_addr 0..8 returns the same words one cycle later; rd_addr 9 returns 0.
- Bubbled input: in_valid toggled 1-0-1 pattern -> only valid cycles write; words land at consecutive addresses 0..8; done after 9 transfers (about 17 cycles).
- Inf/NaN counting: frame containing 0x7FC00000 and 0xFF800000 -> nan_cnt=2; 0x7F7FFFFF (max finite) is not counted.
- Overrun and post-done input:
  - Stimulus: in_valid=1 while IDLE, then 3 extra words after done.
  - Required response: overrun=1; address 0 unchanged; count stays 9; a following start clears overrun=0 and done=0.
- Abort and restart: start at count=4, then write 0x40000000 frame -> count restarts 0; mem[0]=0x40000000 after first transfer; done after 9 new transfers.
- Async reset mid-CAPTURE at count=5 -> in_ready=0, done=0, count=0 immediately without a clock edge; state IDLE.
